rom_arb: RTL

ROM_ARB -- requirements
Module: rom_arb

---
 rtl/rom_arb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rom_arb.sv
// rom_arb: two-port read arbiter in front of a single-port synchronous ROM.
// Each port issues one read at a time; a granted read returns data one cycle
// later and is held until the owning port accepts it.
// Optional feature: define ROM_ARB_RR_EN for round-robin arbitration on
// conflicts. Without it, port 0 always wins and no pointer flop exists.
module rom_arb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             P0_REQ,
  input  logic [AW-1:0]    P0_ADDR,
  output logic             P0_GNT,
  output logic             P0_RVAL,
  input  logic             P0_RRDY,
  output logic [WIDTH-1:0] P0_RDATA,
  input  logic             P1_REQ,
  input  logic [AW-1:0]    P1_ADDR,
  output logic             P1_GNT,
  output logic             P1_RVAL,
  input  logic             P1_RRDY,
  output logic [WIDTH-1:0] P1_RDATA,
  output logic             ROM_EN,
  output logic [AW-1:0]    ROM_ADDR,
  input  logic [WIDTH-1:0] ROM_DO
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          owner_r;
  logic          owner_nxt_s;
  logic          rval0_s;
  logic          rval1_s;
  logic          free_s;
  logic          gnt_any_s;
  logic          pick_s;
  logic [AW-1:0] addr_s;

`ifdef ROM_ARB_RR_EN
  logic prio_r;

  // Round-robin pointer: after every grant the other port gets priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_r <= 1'b0;
    end else if (gnt_any_s) begin
      prio_r <= ~pick_s;
    end else begin
      prio_r <= prio_r;
    end
  end
`endif

  // Read-valid for the owning port; forced low while reset is asserted.
  always_comb begin
    rval0_s = 1'b0;
    rval1_s = 1'b0;
    if (RST) begin
      rval0_s = 1'b0;
      rval1_s = 1'b0;
    end else begin
      rval0_s = (state_r == PEND) & ~owner_r;
      rval1_s = (state_r == PEND) &  owner_r;
    end
  end

  // The ROM is free when nothing is outstanding or the pending response is accepted now.
  always_comb begin
    free_s = 1'b0;
    case (state_r)
      IDLE:    free_s = 1'b1;
      PEND:    free_s = owner_r ? (rval1_s & P1_RRDY) : (rval0_s & P0_RRDY);
      default: free_s = 1'b0;
    endcase
  end

  // Arbitration: pick at most one requesting port when the ROM is free.
  always_comb begin
    gnt_any_s = 1'b0;
    pick_s    = 1'b0;
    if (RST || !free_s) begin
      gnt_any_s = 1'b0;
      pick_s    = 1'b0;
    end else if (P0_REQ && P1_REQ) begin
      gnt_any_s = 1'b1;
`ifdef ROM_ARB_RR_EN
      pick_s    = prio_r;
`else
      pick_s    = 1'b0;
`endif
    end else if (P0_REQ) begin
      gnt_any_s = 1'b1;
      pick_s    = 1'b0;
    end else if (P1_REQ) begin
      gnt_any_s = 1'b1;
      pick_s    = 1'b1;
    end else begin
      gnt_any_s = 1'b0;
      pick_s    = 1'b0;
    end
  end

  // ROM address mux: granted port's address, otherwise all-zeros.
  always_comb begin
    addr_s = {AW{1'b0}};
    if (gnt_any_s) begin
      addr_s = pick_s ? P1_ADDR : P0_ADDR;
    end else begin
      addr_s = {AW{1'b0}};
    end
  end

  // Next-state: a grant opens a pending response; a free cycle without grant returns to idle.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    if (gnt_any_s) begin
      state_nxt_s = PEND;
      owner_nxt_s = pick_s;
    end else if (free_s) begin
      state_nxt_s = IDLE;
      owner_nxt_s = owner_r;
    end else begin
      state_nxt_s = state_r;
      owner_nxt_s = owner_r;
    end
  end

  // State register; reset discards any pending response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
    end
  end

  assign P0_GNT   = gnt_any_s & ~pick_s;
  assign P1_GNT   = gnt_any_s &  pick_s;
  assign ROM_EN   = gnt_any_s;
  assign ROM_ADDR = addr_s;
  assign P0_RVAL  = rval0_s;
  assign P1_RVAL  = rval1_s;
  assign P0_RDATA = ROM_DO;
  assign P1_RDATA = ROM_DO;

endmodule
